// File: rtl/pmod_mic_reader.sv
// PmodMIC3 (ADCS7476) SPI reader: one 16-bit frame per sample tick, 12-bit sample out plus loud detector.
// Latency: valid/err strobe lands 33*CLK_DIV+1 cycles after the tick (133 at defaults); loud follows one cycle later.
// Backpressure: none; a tick that arrives while a frame is in flight is dropped and flagged on overrun.
//
// Ports:
//   CLK_I, rst           system clock, asynchronous active-high reset
//   enable               gates the start of new frames (an in-flight frame always completes)
//   mic_sdata            ADC serial data, sampled on the cycle mic_sclk is driven high
//   mic_cs, mic_sclk     ADC chip select (active-low) and SPI clock (idles high)
//   sample/sample_valid  last good sample and its one-cycle update strobe
//   frame_err, overrun   one-cycle strobes: bad leading bits / tick while busy
//   loud, busy           held loudness level, frame-in-progress level
module pmod_mic_reader #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_DIV   = 2500,
    parameter int THRESH       = 1024,
    parameter int HOLD_SAMPLES = 4000
) (
    input  logic        CLK_I,
    input  logic        rst,
    input  logic        enable,
    input  logic        mic_sdata,
    output logic        mic_cs,
    output logic        mic_sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        loud,
    output logic        busy
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SAMPLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [11:0]   THRESH_V  = 12'(THRESH);
    localparam logic [11:0]   MIDSCALE  = 12'h800;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_QUIET
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DW-1:0]   div_q, div_d;
    logic [3:0]      bit_q, bit_d;
    logic            phase_q, phase_d;      // 0: SCLK low half, 1: SCLK high half
    logic [15:0]     shift_q, shift_d;
    logic [11:0]     sample_q, sample_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            ovr_q, ovr_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            busy_q, busy_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            loud_q, loud_d;

    logic            tick;
    logic            div_last;
    logic [11:0]     mag;

    // Free-running sample-rate timebase, independent of enable and FSM state.
    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign div_last   = (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        phase_d  = phase_q;
        shift_d  = shift_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        ovr_d    = tick && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    state_d = S_SETUP;
                    div_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_last) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_last) begin
                    div_d = '0;
                    if (!phase_q) begin
                        // SCLK is driven high at this edge; the ADC has held
                        // the bit stable through the whole low half.
                        phase_d = 1'b1;
                        shift_d = {shift_q[14:0], mic_sdata};
                    end else if (bit_q == 4'd15) begin
                        // Frame complete: decide the strobe here so that it is
                        // registered and visible during DONE.
                        state_d = S_DONE;
                        if (shift_q[15:12] == 4'b0000) begin
                            sample_d = shift_q[11:0];
                            valid_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        phase_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_QUIET;
                div_d   = '0;
            end
            S_QUIET: begin
                if (div_last) begin
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pin levels follow the next state so that they are plain registers.
        cs_d   = !((state_d == S_SETUP) || (state_d == S_SHIFT));
        sclk_d = !((state_d == S_SHIFT) && !phase_d);
        busy_d = (state_d != S_IDLE);
    end

    // Loudness is judged on the registered sample while its strobe is high,
    // so loud moves one cycle after sample_valid.
    assign mag = sample_q[11] ? (sample_q - MIDSCALE) : (MIDSCALE - sample_q);

    always_comb begin
        hold_d = hold_q;
        loud_d = loud_q;
        if (valid_q) begin
            if (mag > THRESH_V) begin
                hold_d = HOLD_LOAD;
                loud_d = 1'b1;
            end else if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
                loud_d = (hold_q != HOLD_ONE);
            end
        end
    end

    always_ff @(posedge CLK_I or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            shift_q    <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b1;
            busy_q     <= 1'b0;
            hold_q     <= '0;
            loud_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            hold_q     <= hold_d;
            loud_q     <= loud_d;
        end
    end

    assign mic_cs       = cs_q;
    assign mic_sclk     = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign overrun      = ovr_q;
    assign loud         = loud_q;
    assign busy         = busy_q;

endmodule
